// File: rtl/hps_uio_master_if.sv
// hps_uio_master_if: request, write-data, read-data and UIO bus signals of the UIO initiator
//   master modport (initiator side):
//     in : req_valid, req_cmd[7:0], req_len[9:0], wr_data[15:0], wr_valid, io_dout[15:0]
//     out: req_ready, wr_ready, rd_data[15:0], rd_valid, done, err, uio_ena, io_strobe, io_din[15:0]
//   slave modport: the same signals seen from the client/responder side
interface hps_uio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [9:0]  req_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        uio_ena;
    logic        io_strobe;
    logic [15:0] io_din;
    logic [15:0] io_dout;
    modport master (
        input  req_valid, req_cmd, req_len, wr_data, wr_valid, io_dout,
        output req_ready, wr_ready, rd_data, rd_valid, done, err, uio_ena, io_strobe, io_din
    );
    modport slave (
        output req_valid, req_cmd, req_len, wr_data, wr_valid, io_dout,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err, uio_ena, io_strobe, io_din
    );
endinterface

// File: rtl/hps_uio_master.sv
// hps_uio_master: HPS user-IO bus initiator, sends a command word plus req_len data words per transaction
//   clk_sys  in  system clock, rising edge
//   reset    in  asynchronous active-high reset
//   u        hps_uio_master_if.master: request/write/read handshakes and uio_ena/io_strobe/io_din/io_dout
//   Optional feature macro HPS_UIO_TIMEOUT_EN: abort a transaction after TIMEOUT_CYC consecutive
//   write-data stall cycles, flagged by err together with done.
module hps_uio_master #(
    parameter int SETUP_CYC   = 2,
    parameter int GAP_CYC     = 1,
    parameter int IDLE_CYC    = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input logic               clk_sys,
    input logic               reset,
    hps_uio_master_if.master  u
);
    localparam int CMAX = ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) > IDLE_CYC ?
                          ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) : IDLE_CYC;
    localparam int CW = $clog2(CMAX + 1);

    if (SETUP_CYC < 1 || GAP_CYC < 1 || IDLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("hps_uio_master: cycle parameters must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, SETUP, CMD, GAP, DATA, TAIL, RELEASE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [7:0]    cmd_q;
    logic [9:0]    rem;
    logic [15:0]   din_q;
    logic          data_fire, first_gap, timeout;

    assign data_fire   = state == DATA && u.wr_valid;
    assign first_gap   = state == GAP && cnt == '0;
    assign u.req_ready = state == IDLE;
    assign u.wr_ready  = state == DATA;
    assign u.io_strobe = state == CMD || data_fire;
    assign u.io_din    = state == CMD ? {8'h00, cmd_q} : data_fire ? u.wr_data : din_q;
    // uio_ena falls on the TAIL edge, so it is low from the first RELEASE cycle on
    assign u.uio_ena   = state inside {SETUP, CMD, GAP, DATA, TAIL};
    assign u.done      = state == RELEASE && cnt == '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (u.req_valid) state_n = SETUP;
            SETUP:   if (cnt == CW'(SETUP_CYC - 1)) state_n = CMD;
            CMD:     state_n = GAP;
            GAP:     if (cnt == CW'(GAP_CYC - 1)) state_n = (rem != '0) ? DATA : TAIL;
            DATA:    if (u.wr_valid) state_n = GAP; else if (timeout) state_n = TAIL;
            TAIL:    state_n = RELEASE;
            RELEASE: if (cnt == CW'(IDLE_CYC - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // cnt measures time spent in the current state; it restarts on every state change
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
        end
    end

    // responder registers io_dout on a strobe, so the first GAP cycle sees the reply
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cmd_q      <= '0;
            rem        <= '0;
            din_q      <= '0;
            u.rd_data  <= '0;
            u.rd_valid <= 1'b0;
        end else begin
            if (u.req_valid && u.req_ready) begin
                cmd_q <= u.req_cmd;
                rem   <= u.req_len;
            end else if (data_fire) begin
                rem <= rem - 10'(rem != '0);
            end
            if (u.io_strobe) din_q <= u.io_din;
            u.rd_valid <= first_gap;
            if (first_gap) u.rd_data <= u.io_dout;
        end
    end

`ifdef HPS_UIO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    logic          to_flag;
    assign timeout = state == DATA && !u.wr_valid && to_cnt == TW'(TIMEOUT_CYC - 1);
    assign u.err   = u.done && to_flag;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            to_cnt <= (state == DATA && !u.wr_valid) ? to_cnt + 1'b1 : '0;
            if (u.req_valid && u.req_ready) to_flag <= 1'b0;
            else if (timeout) to_flag <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign u.err   = 1'b0;
`endif
endmodule
